denise_collision: RTL

- Collision detector directly downstream of the Denise bitplane serialiser; consumes the 8-bit serial bitplane pixel stream (bpldata[8:1]) plus per-sprite "pixel opaque" flags.
- Accumulates sticky sprite/playfield collision bits in CLXDAT, under CLXCON/CLXCON2 match and enable control.
- Drives read data onto Denise's register read bus, and clears CLXDAT on read.

---
 rtl/denise_collision.sv | 110 +++++++++++
 1 files changed

// File: rtl/denise_collision.sv
// rtl/denise_collision.sv - sprite/playfield collision detector (CLXDAT/CLXCON/CLXCON2)
// Optional macro DENISE_CLXCON2_EN adds CLXCON2 so planes 7/8 join the playfield match.
module denise_collision #(
  parameter logic [8:0] CLXDAT  = 9'h00e,
  parameter logic [8:0] CLXCON  = 9'h098,
  parameter logic [8:0] CLXCON2 = 9'h10e
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        aga,
  input  logic [8:1]  reg_address_in,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic [8:1]  bpldata,
  input  logic [7:0]  nsprite,
  input  logic        window
);

  logic [15:0] clxcon;
  logic [14:0] clxdat;
  logic [14:0] hit;
  logic [8:1]  enbp;
  logic [8:1]  mvbp;
  logic [8:1]  plane_match;
  logic        odd_hit;
  logic        even_hit;
  logic        sg0, sg2, sg4, sg6;
  logic        rd;
  logic        wr_clxcon;

  assign rd        = (reg_address_in == CLXDAT[8:1]);
  assign wr_clxcon = (reg_address_in == CLXCON[8:1]);

`ifdef DENISE_CLXCON2_EN
  // Only ENBP8/7 and MVBP8/7 are meaningful, so only those bits are kept.
  logic [3:0] clxcon2;
  logic       wr_clxcon2;

  assign wr_clxcon2 = aga && (reg_address_in == CLXCON2[8:1]);

  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        clxcon2 <= 4'h0;
      end else if (wr_clxcon) begin
        clxcon2 <= 4'h0;
      end else if (wr_clxcon2) begin
        clxcon2 <= {data_in[7:6], data_in[1:0]};
      end
    end
  end

  assign enbp = {clxcon2[3:2], clxcon[11:6]};
  assign mvbp = {clxcon2[1:0], clxcon[5:0]};
`else
  logic unused_aga;
  assign unused_aga = aga;
  assign enbp = {2'b00, clxcon[11:6]};
  assign mvbp = {2'b00, clxcon[5:0]};
`endif

  // A disabled plane always matches; an enabled one must equal its match value.
  assign plane_match = ~enbp | ~(bpldata ^ mvbp);
  assign odd_hit     = plane_match[1] & plane_match[3] & plane_match[5] & plane_match[7];
  assign even_hit    = plane_match[2] & plane_match[4] & plane_match[6] & plane_match[8];

  assign sg0 = nsprite[0] | (clxcon[12] & nsprite[1]);
  assign sg2 = nsprite[2] | (clxcon[13] & nsprite[3]);
  assign sg4 = nsprite[4] | (clxcon[14] & nsprite[5]);
  assign sg6 = nsprite[6] | (clxcon[15] & nsprite[7]);

  always_comb begin
    hit     = 15'h0000;
    hit[0]  = odd_hit & even_hit;
    hit[1]  = odd_hit & sg0;
    hit[2]  = odd_hit & sg2;
    hit[3]  = odd_hit & sg4;
    hit[4]  = odd_hit & sg6;
    hit[5]  = even_hit & sg0;
    hit[6]  = even_hit & sg2;
    hit[7]  = even_hit & sg4;
    hit[8]  = even_hit & sg6;
    hit[9]  = sg0 & sg2;
    hit[10] = sg0 & sg4;
    hit[11] = sg0 & sg6;
    hit[12] = sg2 & sg4;
    hit[13] = sg2 & sg6;
    hit[14] = sg4 & sg6;
    hit     = hit & {15{window}};
  end

  // Clear-on-read still ORs in this cycle's hits so none are lost.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        clxcon <= 16'h0000;
        clxdat <= 15'h0000;
      end else begin
        clxdat <= (rd ? 15'h0000 : clxdat) | hit;
        if (wr_clxcon) begin
          clxcon <= data_in;
        end
      end
    end
  end

  assign data_out = rd ? {1'b1, clxdat} : 16'h0000;

endmodule
